serial_addsub_ctrl: RTL and testbench

//   Bit-serial add/subtract controller. Time-shares one full_adder cell over a WIDTH-bit word.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/serial_addsub_ctrl_full_adder.sv | 13 +
 rtl/serial_addsub_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_ctrl_full_adder.sv
// One-bit full adder cell that is time-shared by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one full_adder cell, LSB first, one bit per clock.
// Optional signed overflow flag is enabled by defining OVF_DETECT_EN.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic             ready_q;
    logic             done_q;
    logic             carry_q;
    logic             cout_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sreg_a_q;
    logic [WIDTH-1:0] sreg_b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] acc_d;
    logic             fa_s;
    logic             fa_cout;
`ifdef OVF_DETECT_EN
    logic             ovf_q;
`endif

    full_adder u_full_adder (
        .a    (sreg_a_q[0]),
        .b    (sreg_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Sum bits enter from the MSB side so the word is aligned after WIDTH shifts.
    assign acc_d = {fa_s, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
            sreg_a_q <= '0;
            sreg_b_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef OVF_DETECT_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // Subtract is A + ~B + 1: invert B and seed the carry with 1.
                        sreg_a_q <= a;
                        sreg_b_q <= (op == OP_SUB) ? ~b : b;
                        carry_q  <= (op == OP_SUB);
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sreg_a_q <= sreg_a_q >> 1;
                    sreg_b_q <= sreg_b_q >> 1;
                    acc_q    <= acc_d;
                    carry_q  <= fa_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        result_q <= acc_d;
                        cout_q   <= fa_cout;
`ifdef OVF_DETECT_EN
                        // carry_q here is the carry into the MSB.
                        ovf_q    <= carry_q ^ fa_cout;
`endif
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
`ifdef OVF_DETECT_EN
    assign ovf    = ovf_q;
`else
    assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed corner cases plus random operations.
module tb_serial_addsub_ctrl;
    import addsub_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic c, output logic v);
        int ux, uy, sx, sy, us, ss;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
        if (o == OP_SUB) begin
            us = ux - uy;
            ss = sx - sy;
            c  = (ux >= uy);
        end else begin
            us = ux + uy;
            ss = sx + sy;
            c  = (us >= (1 << W));
        end
        r = W'(us);
`ifdef OVF_DETECT_EN
        v = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
`else
        v = 1'b0;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Run one operation; optionally pulse start with junk operands pulse_at edges into RUN.
    task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int pulse_at);
        logic [W-1:0] er, prev_r;
        logic         ec, ev;
        int           n;
        bit           seen_done;
        model(o, x, y, er, ec, ev);
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        chk("ready_before_start", ready === 1'b1, ready, 1'b1);
        prev_r = result;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick;
        start = 1'b0;
        op    = ~o;
        a     = W'($urandom);
        b     = W'($urandom);
        seen_done = 1'b0;
        for (n = 1; n <= 40; n++) begin
            if (pulse_at != 0 && n == pulse_at) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            if (n == W / 2) begin
                chk("ready_low_in_run", ready === 1'b0, ready, 1'b0);
                chk("result_held_in_run", result === prev_r, result, prev_r);
            end
        end
        start = 1'b0;
        chk("done_seen", seen_done === 1'b1, seen_done, 1'b1);
        chk("done_latency", n == W, n, W);
        chk("result", result === er, result, er);
        chk("cout", cout === ec, cout, ec);
        chk("ovf", ovf === ev, ovf, ev);
        chk("ready_low_at_done", ready === 1'b0, ready, 1'b0);
        tick;
        chk("done_one_cycle", done === 1'b0, done, 1'b0);
        chk("ready_after_done", ready === 1'b1, ready, 1'b1);
        chk("result_stable", result === er, result, er);
    endtask

    initial begin
        logic [W-1:0] er, rx, ry;
        logic         ec, ev, ro;
        int           n;
        bit           done_hit;

        rst_n = 1'b0;
        start = 1'b0;
        op    = OP_ADD;
        a     = '0;
        b     = '0;
        #12;
        chk("rst_ready", ready === 1'b1, ready, 1'b1);
        chk("rst_done", done === 1'b0, done, 1'b0);
        chk("rst_result", result === 8'h00, result, 8'h00);
        chk("rst_cout", cout === 1'b0, cout, 1'b0);
        chk("rst_ovf", ovf === 1'b0, ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        do_op(OP_ADD, 8'h0F, 8'h01, 0);
        do_op(OP_ADD, 8'hFF, 8'h01, 0);
        do_op(OP_SUB, 8'h05, 8'h07, 0);
        do_op(OP_SUB, 8'h07, 8'h05, 0);
        do_op(OP_ADD, 8'h7F, 8'h01, 0);
        do_op(OP_SUB, 8'h80, 8'h01, 0);
        do_op(OP_SUB, 8'h5A, 8'h00, 0);
        do_op(OP_SUB, 8'h00, 8'h00, 0);
        do_op(OP_ADD, 8'h80, 8'h80, 0);

        // Start pulse mid-RUN must be ignored and not queued.
        do_op(OP_ADD, 8'h12, 8'h34, 3);
        tick;
        chk("no_queued_start", ready === 1'b1, ready, 1'b1);

        // Start held high: re-accepted on the first IDLE cycle.
        model(OP_SUB, 8'h40, 8'h11, er, ec, ev);
        start = 1'b1;
        op    = OP_ADD;
        a     = 8'h01;
        b     = 8'h02;
        tick;
        op = OP_SUB;
        a  = 8'h40;
        b  = 8'h11;
        done_hit = 1'b0;
        for (n = 0; n < 40; n++) begin
            tick;
            if (done === 1'b1) begin
                done_hit = 1'b1;
                break;
            end
        end
        chk("held_first_done", done_hit === 1'b1, done_hit, 1'b1);
        chk("held_first_result", result === 8'h03, result, 8'h03);
        tick;
        chk("held_idle_ready", ready === 1'b1, ready, 1'b1);
        tick;
        start = 1'b0;
        chk("held_reaccept", ready === 1'b0, ready, 1'b0);
        done_hit = 1'b0;
        for (n = 0; n < 40; n++) begin
            tick;
            if (done === 1'b1) begin
                done_hit = 1'b1;
                break;
            end
        end
        chk("held_second_done", done_hit === 1'b1, done_hit, 1'b1);
        chk("held_second_result", result === er, result, er);
        chk("held_second_cout", cout === ec, cout, ec);
        tick;

        // Reset mid-RUN aborts without a done pulse.
        start = 1'b1;
        op    = OP_ADD;
        a     = 8'h33;
        b     = 8'h44;
        tick;
        start = 1'b0;
        repeat (4) tick;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready === 1'b1, ready, 1'b1);
        chk("abort_result", result === 8'h00, result, 8'h00);
        chk("abort_done", done === 1'b0, done, 1'b0);
        chk("abort_cout", cout === 1'b0, cout, 1'b0);
        done_hit = 1'b0;
        for (n = 0; n < 12; n++) begin
            tick;
            if (n == 1) rst_n = 1'b1;
            if (done === 1'b1) done_hit = 1'b1;
        end
        chk("abort_no_done", done_hit === 1'b0, done_hit, 1'b0);
        chk("abort_result_after", result === 8'h00, result, 8'h00);
        do_op(OP_ADD, 8'h21, 8'h13, 0);

        for (int i = 0; i < 20; i++) begin
            ro = 1'($urandom);
            rx = W'($urandom);
            ry = W'($urandom);
            do_op(ro, rx, ry, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
